// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//   Owns the single register-file write port and shares it between two
//   writeback requesters: A (ALU/link result) and B (load data). Ties are
//   broken round-robin, each requester uses a valid/ready handshake, and the
//   write-port outputs are registered. A clear sequencer can also sweep zeros
//   into every register through the same write port, so the register file
//   itself needs no reset.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   a_valid/a_addr/a_data/a_ready   requester A write channel
//   b_valid/b_addr/b_data/b_ready   requester B write channel
//   clr_req             pulse that starts a clear of all registers
//   clr_done            one-cycle pulse, coincident with the last clear write
//   busy                high on every cycle spent sweeping
//   wr_en/wr_addr/wr_data   registered register-file write port
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_HW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clr_req,
  output logic              clr_done,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  // 1 when B received the most recent grant; a tie goes to the other side.
  logic              last_b;
  logic              sweep_last;

  assign sweep_last = (clr_cnt == {ADDR_W{1'b1}});
  assign busy       = (state == CLEAR);

  // Next-state and handshake decode. A clear request in ARB wins over both
  // requesters, so no ready is raised on the cycle it is seen. In a tie the
  // requester that was not granted last goes first.
  always_comb begin
    state_nx = state;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    unique case (state)
      ARB: begin
        if (clr_req) begin
          state_nx = CLEAR;
        end else begin
          a_ready = a_valid && (!b_valid || last_b);
          b_ready = b_valid && (!a_valid || !last_b);
        end
      end
      CLEAR: begin
        if (sweep_last) begin
          state_nx = ARB;
        end
      end
      default: state_nx = ARB;
    endcase
  end

  // State register plus registered write port. wr_en and clr_done are pulses
  // that default low every cycle; wr_addr/wr_data only move when a write is
  // actually issued, so an idle port keeps showing the last write. A write to
  // r0 with ZERO_HW set completes its handshake but issues nothing, so the
  // port keeps its previous contents. The sweep writes r0 unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      clr_done <= 1'b0;
      clr_cnt  <= '0;
      last_b   <= 1'b1;
    end else begin
      state    <= state_nx;
      wr_en    <= 1'b0;
      clr_done <= 1'b0;
      unique case (state)
        ARB: begin
          if (clr_req) begin
            clr_cnt <= '0;
          end else if (a_ready) begin
            last_b <= 1'b0;
            if (!(ZERO_HW && (a_addr == '0))) begin
              wr_en   <= 1'b1;
              wr_addr <= a_addr;
              wr_data <= a_data;
            end
          end else if (b_ready) begin
            last_b <= 1'b1;
            if (!(ZERO_HW && (b_addr == '0))) begin
              wr_en   <= 1'b1;
              wr_addr <= b_addr;
              wr_data <= b_data;
            end
          end
        end
        CLEAR: begin
          wr_en    <= 1'b1;
          wr_addr  <= clr_cnt;
          wr_data  <= '0;
          clr_cnt  <= clr_cnt + 1'b1;
          clr_done <= sweep_last;
        end
        default: begin
          clr_cnt <= '0;
        end
      endcase
    end
  end

endmodule
